// File: rtl/sum_accumulator.sv
// sum_accumulator: frames N samples of {carry,sum} from an upstream 4-bit adder into an
// AW-bit wrapping total with a sticky overflow flag, released through a valid/ready handshake.
module sum_accumulator #(
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_sum,
    input  logic          in_carry,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_total,
    output logic          out_ovf,
    output logic [3:0]    out_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    localparam logic [3:0] FRAME_CNT = 4'(N);

    state_t        state_p1, state_nxt;
    logic [AW-1:0] total_p1, total_nxt;
    logic [3:0]    count_p1, count_nxt;
    logic          ovf_p1, ovf_nxt;
    logic          vld_p1, vld_nxt;

    logic [4:0]    sample_p0;
    logic [AW:0]   sum_p0;
    logic          accept_p0;

    // Wrapping add; bit AW of the result is the carry out of bit AW-1.
    function automatic logic [AW:0] add_wrap(input logic [AW-1:0] acc, input logic [4:0] smp);
        return {1'b0, acc} + (AW+1)'(smp);
    endfunction

    // Stage p0: sample capture and combinational accumulate
    assign sample_p0 = {in_carry, in_sum};
    assign accept_p0 = in_valid && in_ready;
    assign sum_p0    = add_wrap((state_p1 == ACC) ? total_p1 : '0, sample_p0);

    always_comb begin
        state_nxt = state_p1;
        total_nxt = total_p1;
        count_nxt = count_p1;
        ovf_nxt   = ovf_p1;
        if (clear) begin
            state_nxt = IDLE;
            total_nxt = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state_p1)
                IDLE: begin
                    if (accept_p0) begin
                        total_nxt = sum_p0[AW-1:0];
                        ovf_nxt   = sum_p0[AW];
                        count_nxt = 4'd1;
                        state_nxt = (FRAME_CNT == 4'd1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept_p0) begin
                        total_nxt = sum_p0[AW-1:0];
                        ovf_nxt   = ovf_p1 | sum_p0[AW];
                        count_nxt = count_p1 + 4'd1;
                        if (count_nxt == FRAME_CNT) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                        total_nxt = '0;
                        count_nxt = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    total_nxt = '0;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end
            endcase
        end
        vld_nxt = (state_nxt == DONE);
    end

    // Stage p1: frame state and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= IDLE;
            total_p1 <= '0;
            count_p1 <= '0;
            ovf_p1   <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            state_p1 <= state_nxt;
            total_p1 <= total_nxt;
            count_p1 <= count_nxt;
            ovf_p1   <= ovf_nxt;
            vld_p1   <= vld_nxt;
        end
    end

    assign in_ready  = (state_p1 != DONE);
    assign out_valid = vld_p1;
    assign out_total = total_p1;
    assign out_ovf   = ovf_p1;
    assign out_count = count_p1;

    a_no_ready_when_valid: assert property (@(posedge clk) disable iff (rst) out_valid |-> !in_ready);
    a_count_in_range:      assert property (@(posedge clk) disable iff (rst) count_p1 <= FRAME_CNT);

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: N=4 and N=15 instances share one input stream and are compared
// every cycle against a frame-level model tracking the true (unwrapped) running sum.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_carry, clear, out_ready;
    logic [3:0] in_sum;

    logic       rdy4, vld4, ovf4;
    logic [7:0] tot4;
    logic [3:0] cnt4;
    logic       rdy15, vld15, ovf15;
    logic [7:0] tot15;
    logic [3:0] cnt15;

    int n_chk  = 0;
    int n_fail = 0;

    int unsigned m_sum[2];
    int          m_cnt[2];
    bit          m_done[2];
    int          m_n[2] = '{4, 15};

    always #5 clk = ~clk;

    sum_accumulator #(.N(4), .AW(8)) u_acc4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_sum(in_sum),
        .in_carry(in_carry), .clear(clear), .out_valid(vld4), .out_ready(out_ready),
        .out_total(tot4), .out_ovf(ovf4), .out_count(cnt4)
    );

    sum_accumulator #(.N(15), .AW(8)) u_acc15 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy15), .in_sum(in_sum),
        .in_carry(in_carry), .clear(clear), .out_valid(vld15), .out_ready(out_ready),
        .out_total(tot15), .out_ovf(ovf15), .out_count(cnt15)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sum[i]  = 0;
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
        end
    endfunction

    // Frame-level behaviour: collect N samples, hold the result until taken, clear aborts.
    function automatic void model_step();
        int unsigned smp;
        smp = int'({in_carry, in_sum});
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
            end else if (m_done[i]) begin
                if (out_ready) begin
                    m_sum[i] = 0; m_cnt[i] = 0; m_done[i] = 1'b0;
                end
            end else if (in_valid) begin
                m_sum[i] += smp;
                m_cnt[i]++;
                if (m_cnt[i] == m_n[i]) m_done[i] = 1'b1;
            end
        end
    endfunction

    task automatic check_inst(input string tag, input int i, input logic v, input logic r,
                              input logic [7:0] t, input logic o, input logic [3:0] c);
        check_eq({tag, "_valid"}, v, int'(m_done[i]));
        check_eq({tag, "_ready"}, r, int'(!m_done[i]));
        check_eq({tag, "_total"}, t, m_sum[i] % 256);
        check_eq({tag, "_ovf"},   o, int'(m_sum[i] > 255));
        check_eq({tag, "_count"}, c, m_cnt[i]);
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, "_n4"},  0, vld4,  rdy4,  tot4,  ovf4,  cnt4);
        check_inst({tag, "_n15"}, 1, vld15, rdy15, tot15, ovf15, cnt15);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic c, input logic [3:0] s);
        in_valid = v;
        in_carry = c;
        in_sum   = s;
    endtask

    initial begin
        int pulses;
        rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
        drive(1'b0, 1'b0, 4'd0);
        model_reset();
        @(negedge clk);
        check_all("reset");
        tick("reset_hold");
        rst = 1'b0;

        // Known frame, then hold the result with out_ready low while upstream keeps offering.
        drive(1'b1, 1'b0, 4'd3);  tick("f1_s1");
        drive(1'b1, 1'b1, 4'd5);  tick("f1_s2");
        drive(1'b1, 1'b0, 4'd15); tick("f1_s3");
        drive(1'b1, 1'b1, 4'd15); tick("f1_s4");
        check_eq("f1_valid", vld4, 1);
        check_eq("f1_total", tot4, 70);
        check_eq("f1_ovf",   ovf4, 0);
        check_eq("f1_count", cnt4, 4);
        for (int k = 0; k < 5; k++) begin
            tick("stall");
            check_eq("stall_ready", rdy4, 0);
            check_eq("stall_total", tot4, 70);
        end
        out_ready = 1'b1;
        tick("handshake");
        check_eq("hs_valid", vld4, 0);
        check_eq("hs_total", tot4, 0);
        check_eq("hs_count", cnt4, 0);

        // Longest frame with overflow.
        drive(1'b0, 1'b0, 4'd0); clear = 1'b1; tick("clr_a"); clear = 1'b0;
        drive(1'b1, 1'b1, 4'd15);
        for (int k = 0; k < 15; k++) tick("f15");
        check_eq("f15_valid", vld15, 1);
        check_eq("f15_total", tot15, 209);
        check_eq("f15_ovf",   ovf15, 1);
        check_eq("f15_count", cnt15, 15);

        // Asynchronous reset in the middle of a cycle, mid-frame.
        drive(1'b0, 1'b0, 4'd0); clear = 1'b1; tick("clr_b"); clear = 1'b0;
        drive(1'b1, 1'b0, 4'd1); tick("pre_rst1"); tick("pre_rst2");
        drive(1'b0, 1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check_eq("arst_count", cnt4, 0);
        tick("rst_edge");
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd1);
        for (int k = 0; k < 4; k++) tick("post_rst");
        check_eq("post_rst_total", tot4, 4);
        check_eq("post_rst_valid", vld4, 1);

        // clear wins over a same-cycle accept.
        drive(1'b0, 1'b0, 4'd0); clear = 1'b1; tick("clr_c"); clear = 1'b0;
        drive(1'b1, 1'b0, 4'd7); tick("pre_clr1"); tick("pre_clr2");
        drive(1'b1, 1'b1, 4'd15); clear = 1'b1; tick("clr_accept"); clear = 1'b0;
        check_eq("clr_count", cnt4, 0);
        check_eq("clr_total", tot4, 0);
        drive(1'b1, 1'b0, 4'd2);
        for (int k = 0; k < 4; k++) tick("post_clr");
        check_eq("post_clr_total", tot4, 8);

        // Back-to-back frames with both handshakes held open.
        drive(1'b0, 1'b0, 4'd0); clear = 1'b1; tick("clr_d"); clear = 1'b0;
        out_ready = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            tick("b2b");
            if (vld4) pulses++;
        end
        check_eq("b2b_pulses", pulses, 2);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            clear     = 1'($urandom_range(0, 40) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter N, default 4: samples per accumulation frame; legal range 1..15.
REQ-002 Parameter AW, default 8: accumulator width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream adder result valid.
REQ-006 in_ready  output  1  block can accept a sample this cycle.
REQ-007 in_sum  input  4  4-bit sum from upstream ripple-carry adder.
REQ-008 in_carry  input  1  carry-out from upstream ripple-carry adder.
REQ-009 clear  input  1  synchronous frame abort.
REQ-010 out_valid  output  1  frame result available.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_total  output  AW  accumulated frame total.
REQ-013 out_ovf  output  1  frame total exceeded 2^AW-1.
REQ-014 out_count  output  4  samples accepted in current frame.

Function
REQ-015 Sample value SHALL be the 5-bit unsigned {in_carry,in_sum}, range 0..31, zero-extended to AW+1 bits before addition.
REQ-016 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; in_sum and in_carry are ignored on all other cycles.
REQ-017 The FSM SHALL have exactly three states: IDLE, ACC, DONE.
REQ-018 IDLE: in_ready=1, out_valid=0, out_total=0, out_count=0, out_ovf=0.
REQ-019 On accept in IDLE: total<=sample and count<=1; next state ACC, or DONE if N=1.
REQ-020 ACC: in_ready=1, out_valid=0.
REQ-021 On accept in ACC: total<=(total+sample) mod 2^AW and count<=count+1; if the new count equals N, next state DONE, otherwise stay in ACC.
REQ-022 out_ovf SHALL set when any addition in the frame carries out of bit AW-1, and SHALL remain set (sticky) until the frame ends.
REQ-023 DONE: in_ready=0, out_valid=1; out_total, out_ovf and out_count (=N) SHALL be held stable while out_ready=0.
REQ-024 In DONE with out_ready=1: the handshake completes; next state IDLE; total, count and ovf are zeroed on the same edge.
REQ-025 out_valid SHALL be registered and SHALL assert on the cycle after the edge that captures the Nth accept (1-cycle latency).
REQ-026 in_ready SHALL be a function of state only, with no combinational path from out_ready or in_valid.
REQ-027 While in_ready=0, in_valid SHALL cause no state change; the upstream holds its data.
REQ-028 clear=1 SHALL take priority over accept and output handshake: next state IDLE, total, count and ovf zeroed, and any same-cycle sample or handshake discarded.
REQ-029 Back-to-back frames: the cycle after a DONE handshake, IDLE SHALL accept a new sample with no bubble beyond the one IDLE cycle.

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, force state IDLE and out_total=0, out_ovf=0, out_count=0, out_valid=0, in_ready=1.
REQ-031 Reset asserted mid-frame SHALL discard partial accumulation; the first accept after release starts a fresh frame.
REQ-032 Release of rst SHALL be sampled synchronously; the first state update occurs on the first rising edge with rst=0.

Verification
REQ-033 N=4; accept {0,3},{1,5},{0,15},{1,15} on consecutive cycles -> next cycle out_valid=1, out_total=0x46 (70), out_ovf=0, out_count=4.
REQ-034 N=15; accept 15 samples of {1,15} -> out_total=0xD1 (209), out_ovf=1, out_count=15.
REQ-035 Frame done with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_total held constant; out_ready=1 -> IDLE next cycle with out_total=0, and no input sample consumed.
REQ-036 N=4; after 2 accepts, pulse rst asynchronously mid-cycle -> outputs zero before the next edge; 4 new samples of {0,1} -> out_total=4.
REQ-037 clear=1 on the same cycle as an accept in ACC -> IDLE, out_count=0, sample discarded; the following frame totals only post-clear samples.
REQ-038 Two frames back-to-back with out_ready tied 1 and in_valid tied 1 -> each frame's out_valid pulses for one cycle with the correct independent total.
